// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, single-outstanding instruction-memory
// handshake, one-entry skid buffer for stalled acks, and the IF/ID pipeline register.
module if_stage (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchE,
    input  logic [31:0] BrNPC,
    input  logic        JalrE,
    input  logic [31:0] JalrNPC,
    input  logic        JalD,
    input  logic [31:0] JalNPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    output logic [31:0] PCF,
    output logic [31:0] PCD,
    output logic [31:0] InstrD,
    output logic        ValidD,
    output logic [6:0]  OpD,
    output logic [2:0]  Fn3D,
    output logic [6:0]  Fn7D
);

    localparam logic [1:0]  IDLE = 2'd0;
    localparam logic [1:0]  WAIT = 2'd1;
    localparam logic [1:0]  HOLD = 2'd2;
    localparam logic [1:0]  DROP = 2'd3;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pcf_reg, pcf_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic        started_reg;
    logic [31:0] pcd_reg;
    logic [31:0] instrd_reg;
    logic        validd_reg;

    logic        redirect;
    logic        bubble;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_seq;
    logic        load_fetch;
    logic        load_skid;

    assign redirect   = BranchE | JalrE | JalD;
    assign bubble     = FlushD | BranchE | JalrE;
    assign target_raw = BranchE ? BrNPC : (JalrE ? JalrNPC : JalNPC);
    assign target     = target_raw & 32'hFFFF_FFFC;
    assign pc_seq     = pcf_reg + 32'd4;

    always_comb begin
        state_next      = state_reg;
        pcf_next        = pcf_reg;
        addr_next       = addr_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        load_fetch      = 1'b0;
        load_skid       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (redirect) begin
                    pcf_next = target;
                end
                // One guard cycle after reset release before the first request.
                if (started_reg) begin
                    state_next = WAIT;
                    addr_next  = pcf_next;
                end
            end
            WAIT: begin
                if (ImemAck) begin
                    if (redirect) begin
                        pcf_next = target;
                    end else begin
                        pcf_next = pc_seq;
                        if (StallD) begin
                            skid_instr_next = ImemRdata;
                            skid_pc_next    = pcf_reg;
                            state_next      = HOLD;
                        end else begin
                            load_fetch = 1'b1;
                        end
                    end
                    addr_next = pcf_next;
                end else if (redirect) begin
                    // Request already on the bus: keep its address, discard its data later.
                    pcf_next   = target;
                    state_next = DROP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pcf_next        = target;
                    addr_next       = target;
                    skid_instr_next = NOP;
                    skid_pc_next    = 32'd0;
                    state_next      = WAIT;
                end else if (!StallD) begin
                    load_skid  = 1'b1;
                    addr_next  = pcf_reg;
                    state_next = WAIT;
                end
            end
            DROP: begin
                if (redirect) begin
                    pcf_next = target;
                end
                if (ImemAck) begin
                    addr_next  = pcf_next;
                    state_next = WAIT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state_reg      <= IDLE;
            pcf_reg        <= 32'd0;
            addr_reg       <= 32'd0;
            skid_instr_reg <= NOP;
            skid_pc_reg    <= 32'd0;
            started_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pcf_reg        <= pcf_next;
            addr_reg       <= addr_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            started_reg    <= 1'b1;
        end
    end

    // IF/ID register: bubble beats stall beats load; an unstalled slot with nothing
    // to load becomes empty so an instruction is never issued twice.
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            pcd_reg    <= 32'd0;
            instrd_reg <= NOP;
            validd_reg <= 1'b0;
        end else if (bubble) begin
            instrd_reg <= NOP;
            validd_reg <= 1'b0;
        end else if (StallD) begin
            pcd_reg    <= pcd_reg;
            instrd_reg <= instrd_reg;
            validd_reg <= validd_reg;
        end else if (load_fetch) begin
            pcd_reg    <= pcf_reg;
            instrd_reg <= ImemRdata;
            validd_reg <= 1'b1;
        end else if (load_skid) begin
            pcd_reg    <= skid_pc_reg;
            instrd_reg <= skid_instr_reg;
            validd_reg <= 1'b1;
        end else begin
            instrd_reg <= NOP;
            validd_reg <= 1'b0;
        end
    end

    assign ImemReq  = (state_reg == WAIT) || (state_reg == DROP);
    assign ImemAddr = addr_reg;
    assign PCF      = pcf_reg;
    assign PCD      = pcd_reg;
    assign InstrD   = instrd_reg;
    assign ValidD   = validd_reg;
    assign OpD      = instrd_reg[6:0];
    assign Fn3D     = instrd_reg[14:12];
    assign Fn7D     = instrd_reg[31:25];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked against a
// program-order scoreboard (each delivered instruction must be the next PC's word).
module tb_if_stage;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST;
    logic        StallD, FlushD, BranchE, JalrE, JalD, ImemAck;
    logic [31:0] BrNPC, JalrNPC, JalNPC, ImemRdata;
    logic        ImemReq, ValidD;
    logic [31:0] ImemAddr, PCF, PCD, InstrD;
    logic [6:0]  OpD, Fn7D;
    logic [2:0]  Fn3D;

    int errors = 0;
    int checks = 0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .StallD(StallD), .FlushD(FlushD),
        .BranchE(BranchE), .BrNPC(BrNPC), .JalrE(JalrE), .JalrNPC(JalrNPC),
        .JalD(JalD), .JalNPC(JalNPC), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemAck(ImemAck), .ImemRdata(ImemRdata), .PCF(PCF), .PCD(PCD),
        .InstrD(InstrD), .ValidD(ValidD), .OpD(OpD), .Fn3D(Fn3D), .Fn7D(Fn7D)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
        if (w == NOP) w = 32'h0000_0001;
        return w;
    endfunction

    task automatic step;
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic clear_inputs;
        StallD = 0; FlushD = 0; BranchE = 0; JalrE = 0; JalD = 0; ImemAck = 0;
        BrNPC = 0; JalrNPC = 0; JalNPC = 0; ImemRdata = 0;
    endtask

    task automatic do_reset;
        CPU_RST = 1;
        clear_inputs();
        step();
        step();
        CPU_RST = 0;
    endtask

    task automatic reset_to_wait;
        do_reset();
        step();
        step();
    endtask

    task automatic test_reset;
        CPU_RST = 1;
        clear_inputs();
        step();
        checks++; if (PCF !== 32'd0) begin errors++; $display("FAIL reset_pcf actual=%h required=%h", PCF, 32'd0); end
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL reset_req actual=%b required=0", ImemReq); end
        checks++; if (ImemAddr !== 32'd0) begin errors++; $display("FAIL reset_addr actual=%h required=0", ImemAddr); end
        checks++; if (PCD !== 32'd0) begin errors++; $display("FAIL reset_pcd actual=%h required=0", PCD); end
        checks++; if (InstrD !== NOP) begin errors++; $display("FAIL reset_instr actual=%h required=%h", InstrD, NOP); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", ValidD); end
        checks++; if ({Fn7D, Fn3D, OpD} !== 17'h0_0013) begin errors++; $display("FAIL reset_fields actual=%h required=%h", {Fn7D, Fn3D, OpD}, 17'h0_0013); end
        step();
        CPU_RST = 0;
        step();
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL first_req_edge1 actual=%b required=0", ImemReq); end
        step();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'd0) begin errors++; $display("FAIL first_req_edge2 actual=%b/%h required=1/0", ImemReq, ImemAddr); end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait;
        reset_to_wait();
        for (int k = 0; k < 8; k++) begin
            ImemAck = 1;
            ImemRdata = mem_word(ImemAddr);
            step();
            checks++;
            if (PCD !== 32'(4 * k) || ValidD !== 1'b1 || InstrD !== mem_word(32'(4 * k)) || ImemAddr !== 32'(4 * k + 4)) begin
                errors++;
                $display("FAIL zero_wait_%0d actual=pcd %h v %b instr %h addr %h required=pcd %h v 1 instr %h addr %h",
                         k, PCD, ValidD, InstrD, ImemAddr, 32'(4 * k), mem_word(32'(4 * k)), 32'(4 * k + 4));
            end
        end
        checks++; if (OpD !== InstrD[6:0] || Fn3D !== InstrD[14:12] || Fn7D !== InstrD[31:25]) begin errors++; $display("FAIL decode_fields actual=%h/%h/%h required from %h", OpD, Fn3D, Fn7D, InstrD); end
        clear_inputs();
        $display("test_zero_wait done");
    endtask

    task automatic test_jal_drop;
        reset_to_wait();
        JalD = 1; JalNPC = 32'h100;
        step();
        JalD = 0;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'd0 || PCF !== 32'h100) begin errors++; $display("FAIL jal_drop_hold actual=%b/%h/%h required=1/0/100", ImemReq, ImemAddr, PCF); end
        step();
        checks++; if (ImemAddr !== 32'd0) begin errors++; $display("FAIL jal_drop_hold2 actual=%h required=0", ImemAddr); end
        ImemAck = 1; ImemRdata = mem_word(32'd0);
        step();
        ImemAck = 0;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin errors++; $display("FAIL jal_drop_next actual=%b/%h required=1/100", ImemReq, ImemAddr); end
        checks++; if (InstrD !== NOP || ValidD !== 1'b0) begin errors++; $display("FAIL jal_drop_discard actual=%h/%b required=%h/0", InstrD, ValidD, NOP); end
        ImemAck = 1; ImemRdata = mem_word(32'h100);
        step();
        checks++; if (PCD !== 32'h100 || InstrD !== mem_word(32'h100) || ValidD !== 1'b1) begin errors++; $display("FAIL jal_target_fetch actual=%h/%h required=100/%h", PCD, InstrD, mem_word(32'h100)); end
        clear_inputs();
        $display("test_jal_drop done");
    endtask

    task automatic test_stall_skid;
        reset_to_wait();
        ImemAck = 1; ImemRdata = 32'h00A0_0093; StallD = 1;
        step();
        ImemAck = 0;
        checks++; if (ImemReq !== 1'b0 || ValidD !== 1'b0 || PCF !== 32'd4) begin errors++; $display("FAIL skid_hold actual=%b/%b/%h required=0/0/4", ImemReq, ValidD, PCF); end
        step();
        checks++; if (ImemReq !== 1'b0 || InstrD !== NOP) begin errors++; $display("FAIL skid_hold2 actual=%b/%h required=0/%h", ImemReq, InstrD, NOP); end
        StallD = 0;
        step();
        checks++; if (InstrD !== 32'h00A0_0093 || PCD !== 32'd0 || ValidD !== 1'b1) begin errors++; $display("FAIL skid_release actual=%h/%h/%b required=00a00093/0/1", InstrD, PCD, ValidD); end
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'd4) begin errors++; $display("FAIL skid_next_req actual=%b/%h required=1/4", ImemReq, ImemAddr); end
        clear_inputs();
        $display("test_stall_skid done");
    endtask

    task automatic test_branch_ack;
        reset_to_wait();
        ImemAck = 1; ImemRdata = mem_word(32'd0);
        step();
        checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL branch_pre_valid actual=%b required=1", ValidD); end
        BranchE = 1; BrNPC = 32'h203; ImemRdata = mem_word(32'd4);
        step();
        BranchE = 0; ImemAck = 0;
        checks++; if (InstrD !== NOP || ValidD !== 1'b0) begin errors++; $display("FAIL branch_bubble actual=%h/%b required=%h/0", InstrD, ValidD, NOP); end
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h200 || PCF !== 32'h200) begin errors++; $display("FAIL branch_target actual=%b/%h/%h required=1/200/200", ImemReq, ImemAddr, PCF); end
        BranchE = 1; JalrE = 1; BrNPC = 32'h400; JalrNPC = 32'h500; ImemAck = 1; ImemRdata = 32'h1;
        step();
        checks++; if (ImemAddr !== 32'h400) begin errors++; $display("FAIL branch_priority actual=%h required=400", ImemAddr); end
        BranchE = 0; JalrNPC = 32'h503;
        step();
        checks++; if (ImemAddr !== 32'h500 || ValidD !== 1'b0) begin errors++; $display("FAIL jalr_redirect actual=%h/%b required=500/0", ImemAddr, ValidD); end
        clear_inputs();
        $display("test_branch_ack done");
    endtask

    task automatic test_flush_priority;
        logic [31:0] w0;
        reset_to_wait();
        w0 = mem_word(32'd0);
        ImemAck = 1; ImemRdata = w0;
        step();
        ImemAck = 0; StallD = 1;
        step();
        checks++; if (PCD !== 32'd0 || InstrD !== w0 || ValidD !== 1'b1) begin errors++; $display("FAIL stall_hold actual=%h/%h/%b required=0/%h/1", PCD, InstrD, ValidD, w0); end
        JalD = 1; JalNPC = 32'h40;
        step();
        JalD = 0;
        checks++; if (InstrD !== w0 || ValidD !== 1'b1 || PCF !== 32'h40) begin errors++; $display("FAIL jal_no_bubble actual=%h/%b/%h required=%h/1/40", InstrD, ValidD, PCF, w0); end
        FlushD = 1;
        step();
        checks++; if (InstrD !== NOP || ValidD !== 1'b0) begin errors++; $display("FAIL flush_over_stall actual=%h/%b required=%h/0", InstrD, ValidD, NOP); end
        clear_inputs();
        $display("test_flush_priority done");
    endtask

    task automatic test_wrap;
        reset_to_wait();
        ImemAck = 1; ImemRdata = 32'h1; JalD = 1; JalNPC = 32'hFFFF_FFFE;
        step();
        JalD = 0;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target actual=%b/%h required=1/fffffffc", ImemReq, ImemAddr); end
        ImemRdata = mem_word(32'hFFFF_FFFC);
        step();
        checks++; if (PCD !== 32'hFFFF_FFFC || ImemAddr !== 32'd0 || PCF !== 32'd0) begin errors++; $display("FAIL wrap_next actual=%h/%h/%h required=fffffffc/0/0", PCD, ImemAddr, PCF); end
        clear_inputs();
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid;
        reset_to_wait();
        ImemAck = 1; ImemRdata = mem_word(32'd0);
        step();
        ImemAck = 0;
        step();
        #2;
        CPU_RST = 1;
        #1;
        checks++; if (PCF !== 32'd0 || ImemReq !== 1'b0 || ImemAddr !== 32'd0) begin errors++; $display("FAIL async_reset_fetch actual=%h/%b/%h required=0/0/0", PCF, ImemReq, ImemAddr); end
        checks++; if (PCD !== 32'd0 || InstrD !== NOP || ValidD !== 1'b0) begin errors++; $display("FAIL async_reset_id actual=%h/%h/%b required=0/%h/0", PCD, InstrD, ValidD, NOP); end
        step();
        CPU_RST = 0;
        ImemAck = 1; ImemRdata = mem_word(32'd4);
        step();
        ImemAck = 0;
        checks++; if (ValidD !== 1'b0 || InstrD !== NOP || ImemReq !== 1'b0) begin errors++; $display("FAIL stray_ack actual=%b/%h/%b required=0/%h/0", ValidD, InstrD, ImemReq, NOP); end
        step();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'd0) begin errors++; $display("FAIL restart_req actual=%b/%h required=1/0", ImemReq, ImemAddr); end
        clear_inputs();
        $display("test_reset_mid done");
    endtask

    task automatic test_random;
        logic [31:0] exp_pc, tgt, addr0, pcd0, instr0;
        logic        req0, ack0, stall0, bub0, jal0, valid0;
        int          delivered;
        int          bad;
        reset_to_wait();
        exp_pc = 0;
        delivered = 0;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            StallD = ($urandom % 4) == 0;
            r = $urandom % 16;
            BranchE = (r == 0);
            JalrE   = (r == 1) || (r == 3 && ($urandom % 2 == 0));
            JalD    = (r == 2) || (r == 3);
            BrNPC   = $urandom & 32'h0000_FFFF;
            JalrNPC = $urandom & 32'h0000_FFFF;
            JalNPC  = $urandom & 32'h0000_FFFF;
            if (ImemReq) begin
                ImemAck = ($urandom % 3) == 0;
                ImemRdata = mem_word(ImemAddr);
            end else begin
                ImemAck = ($urandom % 8) == 0;
                ImemRdata = $urandom;
            end
            tgt = BranchE ? BrNPC : (JalrE ? JalrNPC : JalNPC);
            tgt[1:0] = 2'b00;
            req0 = ImemReq; addr0 = ImemAddr; ack0 = ImemAck; stall0 = StallD;
            bub0 = BranchE | JalrE; jal0 = JalD;
            pcd0 = PCD; instr0 = InstrD; valid0 = ValidD;
            step();
            if (req0 && !ack0) begin
                checks++;
                if (ImemReq !== 1'b1 || ImemAddr !== addr0) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL rand_addr_stable cycle %0d actual=%b/%h required=1/%h", c, ImemReq, ImemAddr, addr0);
                end
            end
            if (bub0) begin
                checks++;
                if (InstrD !== NOP || ValidD !== 1'b0) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL rand_bubble cycle %0d actual=%h/%b required=%h/0", c, InstrD, ValidD, NOP);
                end
            end else if (stall0) begin
                checks++;
                if (PCD !== pcd0 || InstrD !== instr0 || ValidD !== valid0) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL rand_stall_hold cycle %0d actual=%h/%h/%b required=%h/%h/%b", c, PCD, InstrD, ValidD, pcd0, instr0, valid0);
                end
            end else if (!jal0 && ValidD === 1'b1) begin
                checks++;
                if (PCD !== exp_pc || InstrD !== mem_word(exp_pc)) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL rand_delivery cycle %0d actual=%h/%h required=%h/%h", c, PCD, InstrD, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (bub0 || jal0) exp_pc = tgt;
        end
        checks++;
        if (delivered < 100) begin errors++; $display("FAIL rand_progress actual=%0d required>=100", delivered); end
        clear_inputs();
        $display("test_random done: %0d instructions delivered", delivered);
    endtask

    initial begin
        CPU_RST = 1;
        clear_inputs();
        test_reset();
        test_zero_wait();
        test_jal_drop();
        test_stall_skid();
        test_branch_ack();
        test_flush_priority();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have one clock, CPU_CLK; reset CPU_RST is asynchronous and active-high.
REQ-002 Ports (name direction width meaning), clock and reset first:
- CPU_CLK in 1: clock, rising edge.
- CPU_RST in 1: async active-high reset.
- StallD in 1: hold the ID register (hazard unit).
- FlushD in 1: bubble into ID next edge.
- BranchE in 1 / BrNPC in 32: taken-branch redirect from EX.
- JalrE in 1 / JalrNPC in 32: jalr redirect from EX.
- JalD in 1 / JalNPC in 32: jal redirect from ID.
- ImemReq out 1 / ImemAddr out 32: instruction-memory request and address.
- ImemAck in 1 / ImemRdata in 32: response strobe and data (data valid in ack cycle).
- PCF out 32: fetch PC.
- PCD out 32 / InstrD out 32 / ValidD out 1: IF/ID register contents.
- OpD out 7, Fn3D out 3, Fn7D out 7: InstrD[6:0], [14:12], [31:25]; these feed the decoder combinationally.
REQ-003 SHALL use NOP = 32'h0000_0013; no parameters.

Function
REQ-004 Redirect SHALL equal BranchE|JalrE|JalD; target priority BrNPC > JalrNPC > JalNPC; target[1:0] forced to 2'b00.
REQ-005 Sequential next PC SHALL be PCF+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-006 Memory handshake: at most one outstanding request; while ImemReq=1, ImemAddr SHALL stay stable until the ImemAck cycle; ImemAck outside a request SHALL be ignored.
REQ-007 FSM states IDLE, WAIT, HOLD, DROP; ImemReq=1 in WAIT and DROP only.
REQ-008 IDLE: next edge -> WAIT with ImemAddr=PCF.
REQ-009 WAIT, no ack, no redirect: hold.
REQ-010 WAIT, no ack, redirect: PCF<=target, ImemAddr keeps old PC, -> DROP.
REQ-011 WAIT, ack, redirect: discard ImemRdata, PCF<=target, stay WAIT; new request starts next cycle with ImemAddr=target.
REQ-012 WAIT, ack, no redirect, !StallD: InstrD<=ImemRdata, PCD<=PCF, ValidD<=1, PCF<=PCF+4, stay WAIT (back-to-back fetch, one instr per ack).
REQ-013 WAIT, ack, no redirect, StallD: latch ImemRdata and PCF in skid buffer, PCF<=PCF+4, -> HOLD.
REQ-014 HOLD: no request; when !StallD, skid -> ID (ValidD<=1), -> WAIT; redirect in HOLD drops skid, PCF<=target, -> WAIT.
REQ-015 DROP: on ack discard data, -> WAIT with ImemAddr=PCF; a further redirect in DROP updates PCF only.
REQ-016 BranchE or JalrE SHALL bubble ID (InstrD<=NOP, ValidD<=0) on the same edge; JalD SHALL NOT bubble ID.
REQ-017 ID-register priority: CPU_RST > FlushD/EX-redirect bubble > StallD hold > load; a bubble with StallD=1 SHALL still bubble.
REQ-018 With StallD=1 and no flush, PCD/InstrD/ValidD SHALL hold.
REQ-019 Latency: ack at edge N -> InstrD valid after edge N (1 cycle) unless stalled.

Reset
REQ-020 CPU_RST=1 SHALL immediately force PCF=0, state IDLE, ImemReq=0, ImemAddr=0, PCD=0, InstrD=NOP, ValidD=0, skid cleared.
REQ-021 Reset mid-request SHALL abandon the request; a late ImemAck after reset release while in IDLE SHALL be ignored.
REQ-022 First request SHALL assert ImemReq on the second rising edge after reset release, ImemAddr=0.

Verification
REQ-023 Zero-wait memory (ack every request cycle), no stalls -> PCD 0,4,8,... one per cycle, ValidD=1 from the first ack onward.
REQ-024 Ack after 3 cycles; JalD with JalNPC=32'h100 in cycle 1 -> ImemAddr held at 0 until ack, data dropped, next request addr 32'h100, InstrD never holds the word for addr 0.
REQ-025 Ack with StallD=1 for 2 cycles, data 32'h00A00093 -> HOLD, ImemReq=0, after release InstrD=32'h00A00093, PCD=0, next ImemAddr=4.
REQ-026 BranchE=1, BrNPC=32'h203 with simultaneous ack -> data discarded, InstrD=NOP, ValidD=0, next ImemAddr=32'h200.
REQ-027 PCF=32'hFFFF_FFFC fetch completes -> next ImemAddr=0.
REQ-028 CPU_RST asserted in WAIT -> all outputs at reset values with no clock edge; no ID load from a subsequent stray ack.
